// File: rtl/seq_pkg.sv
// Shared types and encodings for the control sequencer: FSM states, the two
// supported RV32I opcodes/funct3 values and the ALU control encodings.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } seq_state_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the I (ADDI) and B (BNE) instruction formats,
// sign-extended to the datapath width.
module imm_gen #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm_i,
    output logic [DATA_WIDTH-1:0] imm_b
);

    assign imm_i = {{(DATA_WIDTH - 12){instr[31]}}, instr[31:20]};

    // B-format offsets are always even, so bit 0 is a constant zero.
    assign imm_b = {{(DATA_WIDTH - 13){instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};

    // Register and opcode fields carry no immediate bits.
    logic unused_bits;
    assign unused_bits = ^{instr[19:12], instr[6:0]};

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/execute sequencer for an ADDI/BNE subset: fetches instructions, drives the
// register-file/ALU controls and updates the PC. SEQ_RETIRE_CNT_EN adds retire_cnt.
module ctrl_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH          = 32,
    parameter int unsigned           REG_FILE_ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC            = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    output logic                           instr_req,
    output logic [DATA_WIDTH-1:0]          instr_addr,
    input  logic                           instr_valid,
    input  logic [DATA_WIDTH-1:0]          instr_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
    output logic                           WE3,
    output logic                           ALUsrc,
    output logic                           ALUctrl,
    output logic [DATA_WIDTH-1:0]          ImmOp,
    input  logic                           EQ,
`ifdef SEQ_RETIRE_CNT_EN
    output logic [DATA_WIDTH-1:0]          retire_cnt,
`endif
    output logic                           halt
);

    seq_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   ir_q, ir_d;

    logic [6:0]                     opcode;
    logic [2:0]                     funct3;
    logic [REG_FILE_ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic                           is_addi, is_bne;
    logic [DATA_WIDTH-1:0]          imm_i, imm_b;
    logic [DATA_WIDTH-1:0]          pc_plus4, br_target;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign rd      = REG_FILE_ADDR_WIDTH'(ir_q[11:7]);
    assign rs1     = REG_FILE_ADDR_WIDTH'(ir_q[19:15]);
    assign rs2     = REG_FILE_ADDR_WIDTH'(ir_q[24:20]);
    assign is_addi = (opcode == OPC_OP_IMM) && (funct3 == F3_ADDI);
    assign is_bne  = (opcode == OPC_BRANCH) && (funct3 == F3_BNE);

    imm_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_gen (
        .instr(ir_q[31:0]),
        .imm_i(imm_i),
        .imm_b(imm_b)
    );

    assign pc_plus4  = pc_q + DATA_WIDTH'(4);
    assign br_target = pc_q + imm_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (instr_valid) begin
                    ir_d    = instr_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = run ? StFetch : StIdle;
                if (is_addi) begin
                    pc_d = pc_plus4;
                end else if (is_bne) begin
                    if (EQ) begin
                        pc_d = pc_plus4;
                    end else if (br_target[1]) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = br_target;
                    end
                end else begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controls decode straight from the IR register, so they only move on a capture edge.
    always_comb begin
        AD1     = '0;
        AD2     = '0;
        AD3     = '0;
        ALUsrc  = 1'b0;
        ALUctrl = ALU_ADD;
        ImmOp   = '0;
        if (is_addi) begin
            AD1    = rs1;
            AD3    = rd;
            ALUsrc = 1'b1;
            ImmOp  = imm_i;
        end else if (is_bne) begin
            AD1     = rs1;
            AD2     = rs2;
            ALUctrl = ALU_SUB;
            ImmOp   = imm_b;
        end
    end

    assign WE3        = (state_q == StExec) && is_addi && (rd != '0);
    assign instr_req  = (state_q == StFetch);
    assign instr_addr = pc_q;
    assign halt       = (state_q == StHalt);

`ifdef SEQ_RETIRE_CNT_EN
    logic [DATA_WIDTH-1:0] retire_q;

    // Any EXEC that does not fall into HALT retired a legal instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else if ((state_q == StExec) && (state_d != StHalt)) begin
            retire_q <= retire_q + DATA_WIDTH'(1);
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a fetch responder compares every fetch
// address against a queue of addresses predicted by a small ISA model.
module tb_ctrl_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          instr_req;
    logic [DW-1:0] instr_addr;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] AD1, AD2, AD3;
    logic          WE3, ALUsrc, ALUctrl;
    logic [DW-1:0] ImmOp;
    logic          EQ;
    logic          halt;
`ifdef SEQ_RETIRE_CNT_EN
    logic [DW-1:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    ctrl_sequencer #(
        .DATA_WIDTH(DW),
        .REG_FILE_ADDR_WIDTH(AW),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .instr_req(instr_req),
        .instr_addr(instr_addr),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .AD1(AD1),
        .AD2(AD2),
        .AD3(AD3),
        .WE3(WE3),
        .ALUsrc(ALUsrc),
        .ALUctrl(ALUctrl),
        .ImmOp(ImmOp),
        .EQ(EQ),
`ifdef SEQ_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .halt(halt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] ADDI_X10_5    = 32'h00500513;
    localparam logic [31:0] ADDI_X0_X1_M1 = 32'hFFF08013;
    localparam logic [31:0] BNE_M8        = 32'hFEB51CE3;
    localparam logic [31:0] BNE_M4        = 32'hFE101EE3;
    localparam logic [31:0] BNE_P2        = 32'h00101163;

    // Reference ISA model: next PC, halt and write-enable for one instruction.
    function automatic void model_exec(input logic [31:0] ins, input logic eq,
                                       input logic [31:0] pc, output logic halts,
                                       output logic [31:0] npc, output logic we);
        int          off;
        logic [31:0] tgt;
        halts = 1'b1;
        npc   = pc;
        we    = 1'b0;
        if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
            halts = 1'b0;
            we    = (ins[11:7] != 5'd0);
            npc   = pc + 32'd4;
        end else if (ins[6:0] == 7'h63 && ins[14:12] == 3'd1) begin
            off = int'({ins[7], ins[30:25], ins[11:8]}) * 2;
            if (ins[31]) off = off - 4096;
            if (eq) begin
                halts = 1'b0;
                npc   = pc + 32'd4;
            end else begin
                tgt = pc + 32'(off);
                if (!tgt[1]) begin
                    halts = 1'b0;
                    npc   = tgt;
                end
            end
        end
    endfunction

    task automatic do_reset();
        run         = 1'b0;
        instr_valid = 1'b0;
        EQ          = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    // Answers the next fetch after 'delay' wait cycles; optionally drops run mid-fetch.
    task automatic serve(input logic [31:0] ins, input int delay, input logic eq,
                         input logic drop_run);
        int          waited;
        logic [31:0] exp_addr;
        logic        halts, we;
        logic [31:0] npc;
        waited = 0;
        while (instr_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (instr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_timeout: instr_req=%b required 1", instr_req);
            return;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_fetch: instr_addr=%h required no fetch", instr_addr);
            return;
        end
        exp_addr = exp_q.pop_front();
        if (instr_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL fetch_addr: instr_addr=%h required %h", instr_addr, exp_addr);
        end
        for (int i = 0; i < delay; i++) begin
            if (drop_run && i == 0) run = 1'b0;
            @(negedge clk);
            n_checks++;
            if (instr_req !== 1'b1 || instr_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL fetch_hold: req=%b addr=%h required 1 %h", instr_req,
                         instr_addr, exp_addr);
            end
        end
        model_exec(ins, eq, exp_addr, halts, npc, we);
        instr_valid = 1'b1;
        instr_data  = ins;
        EQ          = eq;
        if (!halts) exp_q.push_back(npc);
        @(negedge clk);
        instr_valid = 1'b0;
        instr_data  = $urandom;
        n_checks++;
        if (WE3 !== we) begin
            n_fail++;
            $display("FAIL exec_we3: WE3=%b required %b (instr %h)", WE3, we, ins);
        end
        @(negedge clk);
        EQ = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        run         = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        EQ          = 1'b0;
        #1;
        n_checks++;
        if ({instr_req, WE3, halt, ALUsrc, ALUctrl} !== 5'b0 || instr_addr !== 32'h0 ||
            {AD1, AD2, AD3} !== 15'h0 || ImmOp !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b we=%b halt=%b addr=%h ad=%h/%h/%h imm=%h required all 0",
                     instr_req, WE3, halt, instr_addr, AD1, AD2, AD3, ImmOp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h0);
        // A response offered with no request must not be captured.
        instr_valid = 1'b1;
        instr_data  = ADDI_X10_5;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (instr_req !== 1'b0 || AD3 !== 5'd0 || ALUsrc !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_fetch: req=%b AD3=%0d ALUsrc=%b required 0 0 0",
                         instr_req, AD3, ALUsrc);
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_fetch_delay();
        run = 1'b1;
        serve(ADDI_X10_5, 3, 1'b0, 1'b0);
        n_checks++;
        if (AD1 !== 5'd0 || AD3 !== 5'd10 || ALUsrc !== 1'b1 || ALUctrl !== 1'b0 ||
            ImmOp !== 32'd5) begin
            n_fail++;
            $display("FAIL addi_decode: AD1=%0d AD3=%0d src=%b ctl=%b imm=%h required 0 10 1 0 5",
                     AD1, AD3, ALUsrc, ALUctrl, ImmOp);
        end
        n_checks++;
        if (WE3 !== 1'b0) begin
            n_fail++;
            $display("FAIL we3_one_cycle: WE3=%b required 0", WE3);
        end
    endtask

    task automatic test_addi();
        serve(ADDI_X0_X1_M1, 0, 1'b0, 1'b0);
        n_checks++;
        if (AD1 !== 5'd1 || AD3 !== 5'd0 || ImmOp !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL addi_neg_decode: AD1=%0d AD3=%0d imm=%h required 1 0 ffffffff",
                     AD1, AD3, ImmOp);
        end
        serve(ADDI_X10_5, 1, 1'b0, 1'b0);
        serve(ADDI_X10_5, 0, 1'b0, 1'b0);
    endtask

    task automatic test_bne();
        serve(BNE_M8, 1, 1'b0, 1'b0);
        n_checks++;
        if (AD1 !== 5'd10 || AD2 !== 5'd11 || ALUsrc !== 1'b0 || ALUctrl !== 1'b1 ||
            ImmOp !== 32'hFFFFFFF8) begin
            n_fail++;
            $display("FAIL bne_decode: AD1=%0d AD2=%0d src=%b ctl=%b imm=%h required 10 11 0 1 fffffff8",
                     AD1, AD2, ALUsrc, ALUctrl, ImmOp);
        end
        serve(ADDI_X10_5, 0, 1'b0, 1'b0);
        serve(ADDI_X10_5, 0, 1'b0, 1'b0);
        serve(BNE_M8, 0, 1'b1, 1'b0);
    endtask

    task automatic test_run_stop();
        serve(ADDI_X10_5, 2, 1'b0, 1'b1);
        repeat (3) begin
            n_checks++;
            if (instr_req !== 1'b0) begin
                n_fail++;
                $display("FAIL run_stop_idle: instr_req=%b required 0", instr_req);
            end
            @(negedge clk);
        end
        run = 1'b1;
        serve(ADDI_X10_5, 0, 1'b0, 1'b0);
        serve(ADDI_X10_5, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        int          waited;
        logic [31:0] exp_addr;
        waited = 0;
        while (instr_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        exp_addr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== exp_addr || exp_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL mid_fetch_setup: req=%b addr=%h required 1 %h (model %h)",
                     instr_req, instr_addr, 32'h20, exp_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (instr_req !== 1'b0 || instr_addr !== 32'h0 || WE3 !== 1'b0 || halt !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b addr=%h we=%b halt=%b required 0 0 0 0",
                     instr_req, instr_addr, WE3, halt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    task automatic test_wrap();
        serve(BNE_M4, 0, 1'b0, 1'b0);
        serve(ADDI_X10_5, 1, 1'b0, 1'b0);
        serve(ADDI_X10_5, 0, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1;
        serve(ADDI_X10_5, 0, 1'b0, 1'b0);
        serve(ADDI_X10_5, 1, 1'b0, 1'b0);
        serve(ADDI_X10_5, 0, 1'b0, 1'b0);
        serve(32'h0000_0000, 0, 1'b0, 1'b0);
        repeat (5) begin
            n_checks++;
            if (halt !== 1'b1 || instr_req !== 1'b0 || instr_addr !== 32'hC || WE3 !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold: halt=%b req=%b addr=%h we=%b required 1 0 0000000c 0",
                         halt, instr_req, instr_addr, WE3);
            end
            @(negedge clk);
        end
`ifdef SEQ_RETIRE_CNT_EN
        n_checks++;
        if (retire_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL retire_cnt: retire_cnt=%0d required 3", retire_cnt);
        end
`endif
    endtask

    task automatic test_misaligned_branch();
        do_reset();
        n_checks++;
        if (halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_cleared: halt=%b required 0", halt);
        end
        run = 1'b1;
        serve(BNE_P2, 0, 1'b0, 1'b0);
        n_checks++;
        if (halt !== 1'b1 || instr_addr !== 32'h0 || instr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL misaligned_halt: halt=%b addr=%h req=%b required 1 0 0",
                     halt, instr_addr, instr_req);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d fetches outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fetch_delay();
        test_addi();
        test_bne();
        test_run_stop();
        test_reset_mid_fetch();
        test_wrap();
        test_halt();
        test_misaligned_branch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
